alu_muldiv: RTL and testbench

Parametrised, clocked successor to the 32-bit ripple ALU, with a registered result. It keeps the same 6-bit MIPS function-code select and single-cycle logic and arithmetic ops, adds sequential signed and unsigned multiply/divide into HI/LO registers, and adds mfhi/mflo readback. It sits in the execute stage and stalls the pipeline through `busy` while a multi-cycle op runs.

---
 rtl/alu_muldiv.sv | 214 +++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle MIPS logic/arithmetic ops with a registered result,
// plus sequential signed/unsigned multiply and divide into HI/LO with mfhi/mflo readback.
module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [5:0]       sel,
   input  logic             start,
   output logic [WIDTH-1:0] dataout,
   output logic             overflow,
   output logic             div_zero,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULT  = 6'd24;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIV   = 6'd26;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_NOR   = 6'd39;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLTU  = 6'd43;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;      // product, or {remainder, dividend/quotient}
   logic [WIDTH-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
   logic [WIDTH-1:0]   a_q, a_d;
   logic               neg_q, neg_d;
   logic               neg_rem_q, neg_rem_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   dataout_q, dataout_d;
   logic               overflow_q, overflow_d;
   logic               div_zero_q, div_zero_d;
   logic               done_q, done_d;

   logic [WIDTH-1:0]   sum, diff, mag_a, mag_b, quo, rem;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod;
   logic               mc_signed;

   assign sum       = a + b;
   assign diff      = a - b;
   assign mc_signed = ~sel[0];
   assign mag_a     = (mc_signed && a[WIDTH-1]) ? -a : a;
   assign mag_b     = (mc_signed && b[WIDTH-1]) ? -b : b;

   // One shift-add step: add the multiplicand when the low multiplier bit is set, then shift right.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_diff  = div_shift - {1'b0, opb_q};

   assign prod = neg_q ? -acc_q : acc_q;
   assign quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opb_d      = opb_q;
      a_d        = a_q;
      neg_d      = neg_q;
      neg_rem_d  = neg_rem_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      dataout_d  = dataout_q;
      overflow_d = overflow_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d     = 1'b1;
               overflow_d = 1'b0;
               case (sel)
                  F_ADD: begin
                     dataout_d  = sum;
                     overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                  end
                  F_SUB: begin
                     dataout_d  = diff;
                     overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
                  end
                  F_AND:  dataout_d = a & b;
                  F_OR:   dataout_d = a | b;
                  F_NOR:  dataout_d = ~(a | b);
                  F_SLT:  dataout_d = {{(WIDTH-1){1'b0}},
                                       diff[WIDTH-1] ^ ((a[WIDTH-1] != b[WIDTH-1]) &&
                                                        (diff[WIDTH-1] != a[WIDTH-1]))};
                  F_SLTU: dataout_d = {{(WIDTH-1){1'b0}}, (a < b)};
                  F_MFHI: dataout_d = hi_q;
                  F_MFLO: dataout_d = lo_q;
                  F_MULT, F_MULTU: begin
                     done_d     = 1'b0;
                     overflow_d = overflow_q;
                     state_d    = S_MUL;
                     cnt_d      = '0;
                     acc_d      = {{WIDTH{1'b0}}, mag_b};
                     opb_d      = mag_a;
                     neg_d      = mc_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  end
                  F_DIV, F_DIVU: begin
                     done_d     = 1'b0;
                     overflow_d = overflow_q;
                     state_d    = S_DIV;
                     cnt_d      = '0;
                     acc_d      = {{WIDTH{1'b0}}, mag_a};
                     opb_d      = mag_b;
                     a_d        = a;
                     neg_d      = mc_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                     neg_rem_d  = mc_signed && a[WIDTH-1];
                     dz_d       = (b == '0);
                  end
                  default: dataout_d = '0;
               endcase
            end
         end

         S_MUL: begin
            if (cnt_q == CW'(WIDTH)) begin
               {hi_d, lo_d} = prod;
               done_d       = 1'b1;
               state_d      = S_IDLE;
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_DIV: begin
            if (cnt_q == CW'(WIDTH)) begin
               // A zero divisor still runs every step; only the written result differs.
               lo_d       = dz_q ? '1 : quo;
               hi_d       = dz_q ? a_q : rem;
               div_zero_d = dz_q;
               done_d     = 1'b1;
               state_d    = S_IDLE;
            end else begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: the iteration datapath is cleared too, so a reset mid-operation leaves no partial result.
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opb_q      <= '0;
         a_q        <= '0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         dataout_q  <= '0;
         overflow_q <= 1'b0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opb_q      <= opb_d;
         a_q        <= a_d;
         neg_q      <= neg_d;
         neg_rem_q  <= neg_rem_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         dataout_q  <= dataout_d;
         overflow_q <= overflow_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

   assign dataout  = dataout_q;
   assign overflow = overflow_q;
   assign div_zero = div_zero_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases plus random ops against
// an arithmetic reference model of the ALU, HI/LO and status flags.
module tb_alu_muldiv;

   localparam int W = 32;

   localparam logic [5:0] F_MFHI  = 6'd16;
   localparam logic [5:0] F_MFLO  = 6'd18;
   localparam logic [5:0] F_MULT  = 6'd24;
   localparam logic [5:0] F_MULTU = 6'd25;
   localparam logic [5:0] F_DIV   = 6'd26;
   localparam logic [5:0] F_DIVU  = 6'd27;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_NOR   = 6'd39;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SLTU  = 6'd43;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -SMAX - 64'sd1;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] a, b;
   logic [5:0]   sel;
   logic         start;
   logic [W-1:0] dataout;
   logic         overflow, div_zero, busy, done;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] hi_m, lo_m, dout_m;
   logic         ovf_m, dz_m;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .b        (b),
      .sel      (sel),
      .start    (start),
      .dataout  (dataout),
      .overflow (overflow),
      .div_zero (div_zero),
      .busy     (busy),
      .done     (done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: architectural effect of one accepted op, from plain arithmetic.
   task automatic model_op(input logic [5:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
      longint          sx, sy, r, q, rm;
      longint unsigned ux, uy, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (s)
         F_ADD:  begin r = sx + sy; dout_m = r[31:0]; ovf_m = (r > SMAX) || (r < SMIN); end
         F_SUB:  begin r = sx - sy; dout_m = r[31:0]; ovf_m = (r > SMAX) || (r < SMIN); end
         F_AND:  begin dout_m = x & y;    ovf_m = 1'b0; end
         F_OR:   begin dout_m = x | y;    ovf_m = 1'b0; end
         F_NOR:  begin dout_m = ~(x | y); ovf_m = 1'b0; end
         F_SLT:  begin dout_m = (sx < sy) ? 32'd1 : 32'd0; ovf_m = 1'b0; end
         F_SLTU: begin dout_m = (ux < uy) ? 32'd1 : 32'd0; ovf_m = 1'b0; end
         F_MFHI: begin dout_m = hi_m; ovf_m = 1'b0; end
         F_MFLO: begin dout_m = lo_m; ovf_m = 1'b0; end
         F_MULT:  begin r  = sx * sy; {hi_m, lo_m} = r;  end
         F_MULTU: begin ur = ux * uy; {hi_m, lo_m} = ur; end
         F_DIV, F_DIVU: begin
            if (y == '0) begin
               lo_m = '1;
               hi_m = x;
               dz_m = 1'b1;
            end else begin
               if (s == F_DIV) begin
                  q  = sx / sy;
                  rm = sx % sy;
               end else begin
                  q  = longint'(ux / uy);
                  rm = longint'(ux % uy);
               end
               lo_m = q[31:0];
               hi_m = rm[31:0];
               dz_m = 1'b0;
            end
         end
         default: begin dout_m = '0; ovf_m = 1'b0; end
      endcase
   endtask

   // Called at a negedge; returns at the negedge following acceptance edge E0.
   task automatic issue(input logic [5:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
      sel   = s;
      a     = x;
      b     = y;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic single(input string tag, input logic [5:0] s,
                         input logic [W-1:0] x, input logic [W-1:0] y);
      issue(s, x, y);
      model_op(s, x, y);
      check({tag, ".dout"}, 64'(dataout), 64'(dout_m));
      check({tag, ".ovf"}, 64'(overflow), 64'(ovf_m));
      check({tag, ".done"}, 64'(done), 64'd1);
   endtask

   // Returns at the negedge where done is first seen, so the next issue lands in the done cycle.
   task automatic multi(input string tag, input logic [5:0] s,
                        input logic [W-1:0] x, input logic [W-1:0] y, input bit intrude);
      int n;
      issue(s, x, y);
      model_op(s, x, y);
      check({tag, ".busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!done && n < 60) begin
         if (intrude && n == 5) begin
            sel   = F_ADD;
            a     = 32'h1234;
            b     = 32'h1;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, ".latency"}, 64'(n), 64'd33);
      check({tag, ".idle"}, 64'(busy), 64'd0);
      if (s == F_DIV || s == F_DIVU)
         check({tag, ".divzero"}, 64'(div_zero), 64'(dz_m));
      if (intrude)
         check({tag, ".dout_kept"}, 64'(dataout), 64'(dout_m));
   endtask

   task automatic readback(input string tag);
      single({tag, ".mfhi"}, F_MFHI, '0, '0);
      single({tag, ".mflo"}, F_MFLO, '0, '0);
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 6))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return W'($urandom_range(0, 9));
         default: return W'($urandom());
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] codes [16];
      logic [5:0] s;
      bit         seen;
      codes = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLTU, F_MFHI, F_MFLO,
                F_MULT, F_MULTU, F_DIV, F_DIVU, 6'd0, 6'd63, 6'd17};
      hi_m = '0; lo_m = '0; dout_m = '0; ovf_m = 1'b0; dz_m = 1'b0;
      reset = 1'b0; start = 1'b0; sel = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;

      check("reset.dout", 64'(dataout), 64'd0);
      check("reset.busy", 64'(busy), 64'd0);
      check("reset.done", 64'(done), 64'd0);
      check("reset.ovf", 64'(overflow), 64'd0);
      check("reset.dz", 64'(div_zero), 64'd0);

      single("add", F_ADD, 32'd5, 32'd3);
      check("add.value", 64'(dataout), 64'd8);
      @(negedge clk);
      check("add.done_drop", 64'(done), 64'd0);
      single("add_ovf", F_ADD, 32'h7FFF_FFFF, 32'd1);
      check("add_ovf.flag", 64'(overflow), 64'd1);
      single("sub_ovf", F_SUB, 32'h8000_0000, 32'd1);
      single("sub", F_SUB, 32'd10, 32'd20);
      single("slt_neg", F_SLT, 32'hFFFF_FFFF, 32'd1);
      single("slt_min", F_SLT, 32'h8000_0000, 32'd1);
      single("sltu", F_SLTU, 32'hFFFF_FFFF, 32'd1);
      single("and", F_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
      single("or", F_OR, 32'hF0F0_1234, 32'h0FF0_FF00);
      single("nor", F_NOR, 32'hF0F0_1234, 32'h0FF0_FF00);
      single("bad_code", 6'd1, 32'hDEAD, 32'hBEEF);

      single("pre_mult", F_ADD, 32'h1111, 32'h2222);
      multi("mult", F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
      readback("mult");
      check("mult.lo_value", 64'(dataout), 64'hFFFF_FFEB);
      multi("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
      readback("multu");
      multi("divu", F_DIVU, 32'd100, 32'd7, 1'b0);
      readback("divu");
      multi("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      readback("div_neg");
      multi("div_min", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      readback("div_min");
      multi("div0", F_DIV, 32'd9, 32'd0, 1'b0);
      readback("div0");
      multi("div_clr", F_DIVU, 32'd10, 32'd3, 1'b0);

      multi("b2b_1", F_MULT, 32'd123, 32'hFFFF_FF00, 1'b0);
      multi("b2b_2", F_MULTU, 32'hABCD_1234, 32'h8765_4321, 1'b0);
      readback("b2b");

      issue(F_MULT, 32'd5, 32'd6);
      repeat (9) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      hi_m = '0; lo_m = '0; dout_m = '0; ovf_m = 1'b0; dz_m = 1'b0;
      check("rst_mid.busy", 64'(busy), 64'd0);
      check("rst_mid.done", 64'(done), 64'd0);
      check("rst_mid.dout", 64'(dataout), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("rst_mid.no_done", 64'(seen), 64'd0);
      readback("rst_mid");

      for (int i = 0; i < 60; i++) begin
         s = codes[$urandom_range(0, 15)];
         if (s >= F_MULT && s <= F_DIVU) begin
            multi("rnd_mc", s, rnd_op(), rnd_op(), 1'b0);
            readback("rnd_mc");
         end else begin
            single("rnd_sc", s, rnd_op(), rnd_op());
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
